// File: rtl/poly_note_clk.sv
// Polyphonic square-wave note oscillator bank: a 2-stage pipeline converts a
// MIDI note to a half-period, which is committed to one of VOICES counters.
module poly_note_clk #(
  parameter int VOICES = 4,
  localparam int VW = (VOICES > 1) ? $clog2(VOICES) : 1,
  localparam int MW = $clog2(VOICES + 1)
) (
  input  logic              CLK24M,
  input  logic              RSTn,
  input  logic              note_wr,
  input  logic [VW-1:0]     wr_voice,
  input  logic [6:0]        wr_note,
  input  logic              wr_gate,
  output logic              busy,
  output logic [VOICES-1:0] wave,
  output logic [MW-1:0]     mix
);

  // Handshake: a write is taken on a rising edge where note_wr=1 and busy=0;
  // busy then stays high for the two pipeline cycles up to and including commit.

  function automatic logic [15:0] base_period(input logic [3:0] sem);
    case (sem)
      4'd0:    base_period = 16'd47975;
      4'd1:    base_period = 16'd45316;
      4'd2:    base_period = 16'd42749;
      4'd3:    base_period = 16'd40374;
      4'd4:    base_period = 16'd38101;
      4'd5:    base_period = 16'd35970;
      4'd6:    base_period = 16'd33948;
      4'd7:    base_period = 16'd32036;
      4'd8:    base_period = 16'd30234;
      4'd9:    base_period = 16'd28541;
      4'd10:   base_period = 16'd26935;
      4'd11:   base_period = 16'd25433;
      default: base_period = 16'd0;
    endcase
  endfunction

  logic          accept;
  logic          s1_vld_q, s1_vld_d;
  logic [VW-1:0] s1_voice_q, s1_voice_d;
  logic          s1_gate_q, s1_gate_d;
  logic [3:0]    s1_sem_q, s1_sem_d;
  logic [3:0]    s1_oct_q, s1_oct_d;
  logic          s2_vld_q, s2_vld_d;
  logic [VW-1:0] s2_voice_q, s2_voice_d;
  logic          s2_gate_q, s2_gate_d;
  logic [15:0]   s2_half_q, s2_half_d;

  logic [15:0]       cnt_q [VOICES];
  logic [15:0]       cnt_d [VOICES];
  logic [15:0]       p_q   [VOICES];
  logic [15:0]       p_d   [VOICES];
  logic [15:0]       pn_q  [VOICES];
  logic [15:0]       pn_d  [VOICES];
  logic [VOICES-1:0] pend_q, pend_d;
  logic [VOICES-1:0] g_q, g_d;
  logic [VOICES-1:0] wave_q, wave_d;
  logic [MW-1:0]     mix_q, mix_d;

  assign busy   = s1_vld_q | s2_vld_q;
  assign accept = note_wr & ~busy;
  assign wave   = wave_q;
  assign mix    = mix_q;

  always_comb begin
    s1_vld_d   = accept;
    s1_voice_d = wr_voice;
    s1_gate_d  = wr_gate;
    s1_sem_d   = 4'(wr_note % 7'd12);
    s1_oct_d   = 4'(wr_note / 7'd12);
    s2_vld_d   = s1_vld_q;
    s2_voice_d = s1_voice_q;
    s2_gate_d  = s1_gate_q;
    s2_half_d  = base_period(s1_sem_q) >> s1_oct_q;
  end

  always_comb begin
    cnt_d  = cnt_q;
    p_d    = p_q;
    pn_d   = pn_q;
    pend_d = pend_q;
    g_d    = g_q;
    wave_d = wave_q;
    for (int i = 0; i < VOICES; i++) begin
      // A released voice keeps running while wave=1 so its high level ends naturally.
      if (g_q[i] || wave_q[i]) begin
        if (cnt_q[i] >= p_q[i]) begin
          cnt_d[i]  = '0;
          wave_d[i] = ~wave_q[i];
          if (pend_q[i] && g_q[i]) p_d[i] = pn_q[i];
          pend_d[i] = 1'b0;
        end else begin
          cnt_d[i] = cnt_q[i] + 16'd1;
        end
      end
      // Out-of-range voice indices never match and are dropped here.
      if (s2_vld_q && (s2_voice_q == VW'(i))) begin
        if (s2_gate_q) begin
          if (!g_q[i]) begin
            p_d[i]    = s2_half_q;
            cnt_d[i]  = '0;
            g_d[i]    = 1'b1;
            pend_d[i] = 1'b0;
          end else begin
            pn_d[i]   = s2_half_q;
            pend_d[i] = 1'b1;
          end
        end else if (g_q[i]) begin
          g_d[i]    = 1'b0;
          pend_d[i] = 1'b0;
          if (!wave_d[i]) cnt_d[i] = '0;
        end
      end
    end
  end

  always_comb begin
    mix_d = '0;
    for (int i = 0; i < VOICES; i++) mix_d = mix_d + MW'(wave_q[i]);
  end

  always_ff @(posedge CLK24M or negedge RSTn) begin
    if (!RSTn) begin
      s1_vld_q   <= 1'b0;
      s1_voice_q <= '0;
      s1_gate_q  <= 1'b0;
      s1_sem_q   <= '0;
      s1_oct_q   <= '0;
      s2_vld_q   <= 1'b0;
      s2_voice_q <= '0;
      s2_gate_q  <= 1'b0;
      s2_half_q  <= '0;
      pend_q     <= '0;
      g_q        <= '0;
      wave_q     <= '0;
      mix_q      <= '0;
      for (int i = 0; i < VOICES; i++) begin
        cnt_q[i] <= '0;
        p_q[i]   <= '0;
        pn_q[i]  <= '0;
      end
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_voice_q <= s1_voice_d;
      s1_gate_q  <= s1_gate_d;
      s1_sem_q   <= s1_sem_d;
      s1_oct_q   <= s1_oct_d;
      s2_vld_q   <= s2_vld_d;
      s2_voice_q <= s2_voice_d;
      s2_gate_q  <= s2_gate_d;
      s2_half_q  <= s2_half_d;
      pend_q     <= pend_d;
      g_q        <= g_d;
      wave_q     <= wave_d;
      mix_q      <= mix_d;
      for (int i = 0; i < VOICES; i++) begin
        cnt_q[i] <= cnt_d[i];
        p_q[i]   <= p_d[i];
        pn_q[i]  <= pn_d[i];
      end
    end
  end

endmodule

// File: tb/tb_poly_note_clk.sv
// Bench for poly_note_clk: a 4-voice instance for tone, retune, busy and release
// behaviour plus a 3-voice instance for out-of-range voice writes.
`timescale 1ns/1ps
module tb_poly_note_clk;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       note_wr = 1'b0;
  logic [1:0] wr_voice = '0;
  logic [6:0] wr_note = '0;
  logic       wr_gate = 1'b0;
  logic       busy;
  logic [3:0] wave;
  logic [2:0] mix;

  logic       note_wr3 = 1'b0;
  logic [1:0] wr_voice3 = '0;
  logic       busy3;
  logic [2:0] wave3;
  logic [1:0] mix3;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_q[$];
  int tbl[12] = '{47975, 45316, 42749, 40374, 38101, 35970,
                  33948, 32036, 30234, 28541, 26935, 25433};

  poly_note_clk #(.VOICES(4)) dut (
    .CLK24M(clk), .RSTn(rst_n), .note_wr(note_wr), .wr_voice(wr_voice),
    .wr_note(wr_note), .wr_gate(wr_gate), .busy(busy), .wave(wave), .mix(mix)
  );

  poly_note_clk #(.VOICES(3)) dut3 (
    .CLK24M(clk), .RSTn(rst_n), .note_wr(note_wr3), .wr_voice(wr_voice3),
    .wr_note(7'd127), .wr_gate(1'b1), .busy(busy3), .wave(wave3), .mix(mix3)
  );

  always #21 clk = ~clk;

  function automatic logic [15:0] half_cycles(input int note);
    half_cycles = 16'((tbl[note % 12] >> (note / 12)) + 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Drives one write and returns just after its commit edge.
  task automatic do_write(input int v, input int note, input logic g);
    wr_voice = 2'(v);
    wr_note  = 7'(note);
    wr_gate  = g;
    note_wr  = 1'b1;
    tick();
    note_wr  = 1'b0;
    tick();
    tick();
  endtask

  task automatic wait_toggle(input int v, input int budget, output int cycles);
    logic start;
    start  = wave[v];
    cycles = -1;
    for (int k = 1; k <= budget && cycles < 0; k++) begin
      tick();
      if (wave[v] !== start) cycles = k;
    end
  endtask

  task automatic test_reset();
    #5;
    n_cmp++; if (wave !== 4'b0) begin n_bad++; $display("FAIL reset_wave got=%b want=0000", wave); end
    n_cmp++; if (mix !== 3'd0) begin n_bad++; $display("FAIL reset_mix got=%0d want=0", mix); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    do_reset();
  endtask

  task automatic test_fast_tone();
    int c;
    logic [15:0] e;
    do_reset();
    wr_voice = 2'd0; wr_note = 7'd127; wr_gate = 1'b1; note_wr = 1'b1;
    tick();
    note_wr = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL tone_busy_c1 got=%b want=1", busy); end
    tick();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL tone_busy_c2 got=%b want=1", busy); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL tone_busy_c3 got=%b want=0", busy); end
    repeat (4) exp_q.push_back(half_cycles(127));
    for (int k = 0; k < 4; k++) begin
      wait_toggle(0, 100, c);
      e = exp_q.pop_front();
      n_cmp++; if (16'(c) !== e) begin n_bad++; $display("FAIL tone_half%0d got=%0d want=%0d", k, c, e); end
    end
    n_cmp++; if (mix !== 3'd1) begin n_bad++; $display("FAIL tone_mix_lag got=%0d want=1", mix); end
    tick();
    n_cmp++; if (mix !== 3'd0) begin n_bad++; $display("FAIL tone_mix_fall got=%0d want=0", mix); end
  endtask

  task automatic test_retune();
    int c;
    logic [15:0] e;
    do_reset();
    do_write(1, 69, 1'b1);
    exp_q.push_back(half_cycles(69));
    wait_toggle(1, 2000, c);
    e = exp_q.pop_front();
    n_cmp++; if (16'(c) !== e) begin n_bad++; $display("FAIL retune_first got=%0d want=%0d", c, e); end
    repeat (400) tick();
    do_write(1, 57, 1'b1);
    exp_q.push_back(half_cycles(69) - 16'd403);
    exp_q.push_back(half_cycles(57));
    exp_q.push_back(half_cycles(57));
    for (int k = 0; k < 3; k++) begin
      wait_toggle(1, 4000, c);
      e = exp_q.pop_front();
      n_cmp++; if (16'(c) !== e) begin n_bad++; $display("FAIL retune_half%0d got=%0d want=%0d", k, c, e); end
    end
  endtask

  task automatic test_busy_reject();
    int hi3;
    int rise;
    logic [15:0] e;
    do_reset();
    wr_voice = 2'd2; wr_note = 7'd127; wr_gate = 1'b1; note_wr = 1'b1;
    tick();
    wr_voice = 2'd3;
    tick();
    note_wr = 1'b0;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reject_busy got=%b want=0", busy); end
    exp_q.push_back(half_cycles(127));
    hi3 = 0;
    rise = -1;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (wave[3]) hi3++;
      if (wave[2] && rise < 0) rise = k;
    end
    e = exp_q.pop_front();
    n_cmp++; if (16'(rise) !== e) begin n_bad++; $display("FAIL reject_first_rise got=%0d want=%0d", rise, e); end
    n_cmp++; if (hi3 !== 0) begin n_bad++; $display("FAIL reject_voice3 got=%0d want=0", hi3); end
  endtask

  task automatic test_release();
    int c;
    int hi;
    logic reached;
    logic [15:0] e;
    do_reset();
    for (int v = 0; v < 4; v++) do_write(v, 60, 1'b1);
    reached = 1'b0;
    for (int k = 0; k < 2000 && !reached; k++) begin
      tick();
      if (mix == 3'd4) reached = 1'b1;
    end
    n_cmp++; if (reached !== 1'b1) begin n_bad++; $display("FAIL release_mix4 got=%b want=1", reached); end
    do_write(0, 60, 1'b0);
    exp_q.push_back(half_cycles(60) - 16'd13);
    wait_toggle(0, 2000, c);
    e = exp_q.pop_front();
    n_cmp++; if (16'(c) !== e) begin n_bad++; $display("FAIL release_fall got=%0d want=%0d", c, e); end
    tick();
    n_cmp++; if (mix !== 3'd3) begin n_bad++; $display("FAIL release_mix3 got=%0d want=3", mix); end
    do_write(1, 60, 1'b0);
    n_cmp++; if (mix !== 3'd2) begin n_bad++; $display("FAIL release_mix2 got=%0d want=2", mix); end
    do_write(2, 60, 1'b0);
    n_cmp++; if (mix !== 3'd1) begin n_bad++; $display("FAIL release_mix1 got=%0d want=1", mix); end
    do_write(3, 60, 1'b0);
    n_cmp++; if (mix !== 3'd0) begin n_bad++; $display("FAIL release_mix0 got=%0d want=0", mix); end
    hi = 0;
    repeat (3200) begin
      tick();
      if (wave != 4'b0 || mix != 3'd0) hi++;
    end
    n_cmp++; if (hi !== 0) begin n_bad++; $display("FAIL release_silent got=%0d want=0", hi); end
  endtask

  task automatic test_oob();
    int bad;
    do_reset();
    wr_voice3 = 2'd3; note_wr3 = 1'b1;
    tick();
    note_wr3 = 1'b0;
    n_cmp++; if (busy3 !== 1'b1) begin n_bad++; $display("FAIL oob_busy_c1 got=%b want=1", busy3); end
    tick();
    n_cmp++; if (busy3 !== 1'b1) begin n_bad++; $display("FAIL oob_busy_c2 got=%b want=1", busy3); end
    tick();
    n_cmp++; if (busy3 !== 1'b0) begin n_bad++; $display("FAIL oob_busy_c3 got=%b want=0", busy3); end
    bad = 0;
    repeat (200) begin
      tick();
      if (wave3 != 3'b0 || mix3 != 2'd0) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL oob_quiet got=%0d want=0", bad); end
  endtask

  task automatic test_reset_mid();
    int c;
    int bad;
    logic [15:0] e;
    do_reset();
    do_write(0, 127, 1'b1);
    exp_q.push_back(half_cycles(127));
    wait_toggle(0, 100, c);
    e = exp_q.pop_front();
    n_cmp++; if (16'(c) !== e) begin n_bad++; $display("FAIL rmid_rise got=%0d want=%0d", c, e); end
    tick();
    n_cmp++; if (mix !== 3'd1) begin n_bad++; $display("FAIL rmid_mix_pre got=%0d want=1", mix); end
    wr_voice = 2'd1; wr_note = 7'd60; wr_gate = 1'b1; note_wr = 1'b1;
    tick();
    note_wr = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rmid_busy_pre got=%b want=1", busy); end
    #5;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (wave !== 4'b0) begin n_bad++; $display("FAIL rmid_wave got=%b want=0000", wave); end
    n_cmp++; if (mix !== 3'd0) begin n_bad++; $display("FAIL rmid_mix got=%0d want=0", mix); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy got=%b want=0", busy); end
    tick();
    rst_n = 1'b1;
    bad = 0;
    repeat (300) begin
      tick();
      if (wave != 4'b0 || busy) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL rmid_no_commit got=%0d want=0", bad); end
  endtask

  initial begin
    test_reset();
    test_fast_tone();
    test_retune();
    test_busy_reject();
    test_release();
    test_oob();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
